// File: rtl/cpu_trace_checker_p.sv
// cpu_trace_checker_p: sniffs a CPU trace stream one ASCII character per clock.
// It parses register-write and memory-write lines, classifies each well-formed
// line, flags semantic errors and keeps running line and error counters.
module cpu_trace_checker_p #(
  parameter int unsigned TIME_DIGITS = 4,
  parameter int unsigned GRF_DIGITS  = 4,
  parameter int unsigned NUM_REGS    = 32,
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_4fff,
  parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic [15:0]      freq,
  output logic [1:0]       format_type,
  output logic [4:0]       error_code,
  output logic [CNT_W-1:0] line_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned MAX_DIGITS = (TIME_DIGITS > GRF_DIGITS) ? TIME_DIGITS : GRF_DIGITS;
  localparam int unsigned DEC_W      = $clog2(MAX_DIGITS + 1);
  localparam logic [DEC_W-1:0] TIME_LIM = DEC_W'(TIME_DIGITS);
  localparam logic [DEC_W-1:0] GRF_LIM  = DEC_W'(GRF_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_COLON, S_SP1, S_GRF, S_MEMADDR, S_SP2,
    S_LT, S_EQ, S_SP3, S_DATA, S_HASH, S_DONE_REG, S_DONE_MEM
  } state_t;

  state_t           state, state_n;
  logic [31:0]      time_q, time_n;
  logic [31:0]      pc_q, pc_n;
  logic [31:0]      addr_q, addr_n;
  logic [31:0]      grf_q, grf_n;
  logic [31:0]      data_q, data_n;
  logic [2:0]       hex_cnt, hex_cnt_n;
  logic [DEC_W-1:0] dec_cnt, dec_cnt_n;
  logic             is_mem, is_mem_n;
  logic [31:0]      prev_time;
  logic             have_prev;
  logic [4:0]       err_q, err_n;
  logic             line_done;

  logic             is_dec, is_hex;
  logic [3:0]       nibble;
  logic [31:0]      dec_value;
  logic [15:0]      time_mask;

  // Classify the incoming character and decode its digit value.
  always_comb begin
    is_dec    = (char >= 8'h30) && (char <= 8'h39);
    is_hex    = is_dec || ((char >= 8'h61) && (char <= 8'h66));
    nibble    = is_dec ? 4'(char - 8'h30) : 4'(char - 8'h57);
    dec_value = {28'd0, nibble};
  end

  // Next-state and field accumulation; '^' resynchronises from any state.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    time_n    = time_q;
    pc_n      = pc_q;
    addr_n    = addr_q;
    grf_n     = grf_q;
    data_n    = data_q;
    hex_cnt_n = hex_cnt;
    dec_cnt_n = dec_cnt;
    is_mem_n  = is_mem;
    line_done = 1'b0;

    if (char == 8'h5e) begin
      state_n   = S_TIME;
      time_n    = '0;
      pc_n      = '0;
      addr_n    = '0;
      grf_n     = '0;
      data_n    = '0;
      hex_cnt_n = '0;
      dec_cnt_n = '0;
      is_mem_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE: state_n = S_IDLE;
        S_TIME: begin
          if (is_dec && (dec_cnt != TIME_LIM)) begin
            time_n    = time_q * 32'd10 + dec_value;
            dec_cnt_n = dec_cnt + 1'b1;
          end else if ((char == 8'h40) && (dec_cnt != '0)) begin
            state_n   = S_PC;
            hex_cnt_n = '0;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_PC: begin
          if (is_hex) begin
            pc_n      = {pc_q[27:0], nibble};
            hex_cnt_n = hex_cnt + 1'b1;
            if (hex_cnt == 3'd7) state_n = S_COLON;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_COLON: state_n = (char == 8'h3a) ? S_SP1 : S_IDLE;
        S_SP1: begin
          if (char == 8'h20) begin
            state_n = S_SP1;
          end else if (char == 8'h24) begin
            state_n   = S_GRF;
            dec_cnt_n = '0;
            is_mem_n  = 1'b0;
          end else if (char == 8'h2a) begin
            state_n   = S_MEMADDR;
            hex_cnt_n = '0;
            is_mem_n  = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_GRF: begin
          if (is_dec && (dec_cnt != GRF_LIM)) begin
            grf_n     = grf_q * 32'd10 + dec_value;
            dec_cnt_n = dec_cnt + 1'b1;
          end else if ((char == 8'h20) && (dec_cnt != '0)) begin
            state_n = S_SP2;
          end else if ((char == 8'h3c) && (dec_cnt != '0)) begin
            state_n = S_LT;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_MEMADDR: begin
          if (is_hex) begin
            addr_n    = {addr_q[27:0], nibble};
            hex_cnt_n = hex_cnt + 1'b1;
            if (hex_cnt == 3'd7) state_n = S_SP2;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_SP2: begin
          if (char == 8'h20)      state_n = S_SP2;
          else if (char == 8'h3c) state_n = S_LT;
          else                    state_n = S_IDLE;
        end
        S_LT: state_n = (char == 8'h3d) ? S_EQ : S_IDLE;
        S_EQ, S_SP3: begin
          if (char == 8'h20) begin
            state_n = S_SP3;
          end else if (is_hex) begin
            data_n    = {28'd0, nibble};
            hex_cnt_n = 3'd1;
            state_n   = S_DATA;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_DATA: begin
          if (is_hex) begin
            data_n    = {data_q[27:0], nibble};
            hex_cnt_n = hex_cnt + 1'b1;
            if (hex_cnt == 3'd7) state_n = S_HASH;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_HASH: begin
          if (char == 8'h23) begin
            state_n   = is_mem ? S_DONE_MEM : S_DONE_REG;
            line_done = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Semantic error bits from the captured fields of the line being closed.
  always_comb begin
    time_mask = (freq >> 1) - 16'd1;
    err_n[0]  = |(time_q & {16'd0, time_mask});
    err_n[1]  = (pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI);
    err_n[2]  = is_mem && ((addr_q[1:0] != 2'b00) || (addr_q > ADDR_HI));
    err_n[3]  = !is_mem && (grf_q >= 32'(NUM_REGS));
    err_n[4]  = have_prev && (time_q <= prev_time);
  end

  // State, accumulators, history and saturating counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      time_q     <= '0;
      pc_q       <= '0;
      addr_q     <= '0;
      grf_q      <= '0;
      data_q     <= '0;
      hex_cnt    <= '0;
      dec_cnt    <= '0;
      is_mem     <= 1'b0;
      prev_time  <= '0;
      have_prev  <= 1'b0;
      err_q      <= '0;
      line_count <= '0;
      err_count  <= '0;
    end else begin
      state   <= state_n;
      time_q  <= time_n;
      pc_q    <= pc_n;
      addr_q  <= addr_n;
      grf_q   <= grf_n;
      data_q  <= data_n;
      hex_cnt <= hex_cnt_n;
      dec_cnt <= dec_cnt_n;
      is_mem  <= is_mem_n;
      if (line_done) begin
        err_q     <= err_n;
        prev_time <= time_q;
        have_prev <= 1'b1;
        if (line_count != CNT_MAX) line_count <= line_count + 1'b1;
        if ((err_n != 5'd0) && (err_count != CNT_MAX)) err_count <= err_count + 1'b1;
      end
    end
  end

  // Report classification only during the cycle spent in a DONE state.
  always_comb begin
    format_type = 2'b00;
    error_code  = 5'd0;
    if (state == S_DONE_REG) begin
      format_type = 2'b01;
      error_code  = err_q;
    end else if (state == S_DONE_MEM) begin
      format_type = 2'b10;
      error_code  = err_q;
    end
  end

endmodule

// File: doc/cpu_trace_checker_p.md
Name: cpu_trace_checker_p

Overview:
Parametrised successor of the single-channel CPU trace checker. It consumes one ASCII character per clock, parses register-write and memory-write trace lines, classifies each well-formed line, and flags semantic errors. New over the previous generation:
- configurable ranges and digit limits
- '^' resynchronisation from any state
- time-monotonicity check
- running line/error counters
It sits beside the CPU testbench, sniffing the trace stream.

Parameters:
TIME_DIGITS, 4, max decimal digits of time field (1..TIME_DIGITS accepted)
GRF_DIGITS, 4, max decimal digits of register index
NUM_REGS, 32, register index must be < NUM_REGS
PC_LO, 32'h0000_3000, lowest legal PC (inclusive)
PC_HI, 32'h0000_4fff, highest legal PC (inclusive)
ADDR_HI, 32'h0000_2fff, highest legal data address (inclusive)
CNT_W, 16, width of line/error counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
char  in  8  ASCII character sampled every posedge
freq  in  16  time granularity; freq/2 is a power of two ≥1
format_type  out  2  00 none, 01 register line, 10 memory line
error_code  out  5  bit0 time, bit1 pc, bit2 addr, bit3 grf, bit4 non-monotonic time
line_count  out  CNT_W  well-formed lines since reset, saturating
err_count  out  CNT_W  well-formed lines with error_code≠0, saturating

Behaviour:
Reset (synchronous, active-high; clock clk):
- FSM goes to IDLE; all field accumulators, prev_time, have_prev and counters clear.
- format_type = 0, error_code = 0 on the cycle after reset.

Grammar, one char per cycle:
- Register line: ^ T @ P : S* $ G S* < = S* D #
- Memory line: ^ T @ P : S* * A S* < = S* D #
- T: 1..TIME_DIGITS decimal digits. G: 1..GRF_DIGITS decimal digits.
- P, A, D: exactly 8 lowercase hex digits.
- S: space. No other whitespace is legal.

FSM:
- States: IDLE, TIME, PC, COLON, SP1, GRF, MEMADDR, SP2, LT, EQ, SP3, DATA, HASH, DONE_REG, DONE_MEM.
- A hex-digit counter (3 bits) and a decimal-digit counter track field lengths.
- Any illegal char returns the FSM to IDLE, with one exception: '^' in any state (including DONE_*) clears the accumulators and enters TIME. This is resync.
- Overlong fields → IDLE.
- Accumulation: decimal field = field*10 + digit; hex field = field<<4 | nibble. Both are 32-bit and wrap modulo 2^32.

Output timing:
- The '#' clocked in at edge N moves the FSM to DONE_REG or DONE_MEM.
- format_type and error_code are valid only during the cycle after edge N; otherwise both are 0.
- The next edge leaves DONE_* (to TIME on '^', else IDLE).

Error bits, evaluated from the captured fields; unused bits are 0:
- bit0: (time & (freq/2−1)) ≠ 0.
- bit1: pc[1:0] ≠ 0 or pc < PC_LO or pc > PC_HI. Applies to both line types.
- bit2 (memory lines only): addr[1:0] ≠ 0 or addr > ADDR_HI.
- bit3 (register lines only): grf ≥ NUM_REGS.
- bit4: have_prev and time ≤ prev_time.

Update at edge N:
- prev_time ← time and have_prev ← 1, regardless of the errors reported.
- line_count increments; err_count increments if any error bit is set. Both hold at all-ones (saturate).

Other rules:
- Lines aborted by a resync or by an illegal char do not touch prev_time or the counters.
- freq changes mid-line apply at DONE evaluation.

Test Plan:
1. freq=4; "^10@00003000: $1 <= 0000000a#" → format_type=01 for exactly 1 cycle after '#', error_code=00000, line_count=1, err_count=0.
2. freq=4, continuing from 1; "^7@00003002:*00003000 <= 12345678#" → format_type=10. error_code=00111: time odd, pc misaligned, addr>ADDR_HI. Time 7 ≤ 10 also sets bit4, so error_code=10111 and err_count=1.
3. "^20@00004ffc: $32 <= ffffffff#" with NUM_REGS=32 → format_type=01, error_code=01000; "$31" on the same line → 00000.
4. Resync: "^12@0000^14@00003004: $2 <= 00000001#" → one line reported with time=14, format_type=01, line_count incremented by exactly 1.
5. Malformed: "^12345@..." (5 digits), a 7-digit pc, "<  =", or an uppercase hex digit → format_type stays 00 and the counters are unchanged. Assert reset mid-line → no output, then a clean line parses normally with have_prev=0.
6. CNT_W=2: feed 5 well-formed erroneous lines → line_count and err_count saturate at 3.
